uart_doc_loader: RTL

Serial receive path for the document store. It takes 8N1 UART frames on `RsRx` and writes each valid byte into the document RAM at an auto-incrementing address. A one-byte holding buffer and a `grant` handshake let the text editor arbitrate access to the shared write port. It complements the transmit-side messenger, so document text can be loaded from a host as well as sent to one.

---
 rtl/uart_doc_loader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_doc_loader.sv
// uart_doc_loader
// Receives 8N1 UART frames on RsRx and writes each valid byte into the
// document RAM at an auto-incrementing address. A single-byte holding
// buffer waits for `grant` before the write is issued.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   RsRx       UART line (idle high, asynchronous to clk)
//   grant      document write port is free this cycle
//   doc_a      document write address
//   doc_d      document write data
//   doc_we     one-cycle write strobe per byte
//   wr_count   bytes written since reset or form feed
//   full       wr_count has reached DOC_DEPTH
//   rx_busy    receiver is inside a frame
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, byte lost because the buffer was occupied
module uart_doc_loader #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int ADDR_W    = 9,
  parameter int DOC_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RsRx,
  input  logic              grant,
  output logic [ADDR_W-1:0] doc_a,
  output logic [7:0]        doc_d,
  output logic              doc_we,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DOC_DEPTH);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
  localparam logic [7:0]        FORM_FEED = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Synchronizer and edge detector
  logic       sync1_q;
  logic       rx_s_q;
  logic       rx_prev_q;
  logic [1:0] settle_q;
  logic       fall_s;

  // Receiver
  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;

  // Holding buffer and write port
  logic            pend_q;
  logic            pend_d;
  logic [7:0]      buf_q;
  logic [ADDR_W:0] wr_count_q;
  logic [ADDR_W:0] wr_count_d;
  logic            full_q;
  logic            doc_we_q;
  logic [ADDR_W-1:0] doc_a_q;
  logic [7:0]      doc_d_q;
  logic            rx_busy_q;
  logic            frame_err_q;
  logic            overrun_q;

  logic stop_hit_s;
  logic byte_ok_s;
  logic is_ff_s;
  logic write_go_s;
  logic load_s;
  logic lost_s;

  // Two-flop synchronizer; edge detection is held off until the chain has
  // flushed its reset value, so a line that is already low after reset
  // cannot look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      sync1_q <= RsRx;
      rx_s_q  <= sync1_q;
      if (settle_q != 2'd2) begin
        settle_q  <= settle_q + 2'd1;
        rx_prev_q <= 1'b0;
      end else begin
        rx_prev_q <= rx_s_q;
      end
    end
  end

  assign fall_s = rx_prev_q && !rx_s_q;

  // Dispatch decisions at the stop-sample edge and write-port next state
  always_comb begin
    stop_hit_s = (state_q == ST_STOP) && (baud_q == BAUD_LAST);
    byte_ok_s  = stop_hit_s && rx_s_q;
    is_ff_s    = byte_ok_s && (shift_q == FORM_FEED);
    // A pending byte is never written once full; it is discarded below.
    write_go_s = pend_q && grant && !full_q;
    load_s     = byte_ok_s && !is_ff_s && !full_q && (!pend_q || write_go_s);
    lost_s     = byte_ok_s && !is_ff_s && !full_q && pend_q && !write_go_s;

    pend_d = pend_q;
    if (write_go_s) begin
      pend_d = 1'b0;
    end else if (pend_q && full_q) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (is_ff_s) begin
      pend_d = 1'b0;
    end else if (load_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    // Form feed clear wins over a write issued at the same edge.
    if (is_ff_s) begin
      wr_count_d = '0;
    end else if (write_go_s) begin
      wr_count_d = wr_count_q + ONE_C;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Receiver FSM, holding buffer and registered document-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      pend_q      <= 1'b0;
      buf_q       <= 8'h00;
      wr_count_q  <= '0;
      full_q      <= 1'b0;
      doc_we_q    <= 1'b0;
      doc_a_q     <= '0;
      doc_d_q     <= 8'h00;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      doc_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= lost_s;

      if (write_go_s) begin
        doc_we_q <= 1'b1;
        doc_a_q  <= wr_count_q[ADDR_W-1:0];
        doc_d_q  <= buf_q;
      end
      if (load_s) begin
        buf_q <= shift_q;
      end
      pend_q     <= pend_d;
      wr_count_q <= wr_count_d;
      full_q     <= (wr_count_d == DEPTH_C);

      case (state_q)
        ST_IDLE: begin
          if (fall_s) begin
            state_q   <= ST_START;
            baud_q    <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_q == HALF_LAST) begin
            baud_q <= '0;
            bit_q  <= 3'd0;
            if (!rx_s_q) begin
              state_q <= ST_DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_q == BAUD_LAST) begin
            // Re-arm at mid-stop so back-to-back frames are caught.
            baud_q      <= '0;
            state_q     <= ST_IDLE;
            rx_busy_q   <= 1'b0;
            frame_err_q <= !rx_s_q;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign doc_a     = doc_a_q;
  assign doc_d     = doc_d_q;
  assign doc_we    = doc_we_q;
  assign wr_count  = wr_count_q;
  assign full      = full_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
